// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: computes DIFF = A - B - BIN, resolving CHUNK bits per cycle.
// Latency: N = SIZE/CHUNK cycles from input accept to out_valid. One operation is in flight at a time.
// Backpressure: in_ready is high only in IDLE. Results hold in DONE until out_ready is high.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid/in_ready    operand handshake (A, B, BIN)
//   out_valid/out_ready  result handshake (DIFF, BOUT, OVF)
//   A, B [SIZE]          minuend and subtrahend
//   BIN                  borrow-in
//   DIFF [SIZE]          (A - B - BIN) mod 2^SIZE
//   BOUT                 borrow-out (A < B + BIN, unsigned)
//   OVF                  two's-complement overflow of the signed subtraction
// SIZE must be an integer multiple of CHUNK.

module serial_ripple_subtractor #(
  parameter int SIZE  = 10,
  parameter int CHUNK = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            BIN,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] DIFF,
  output logic            BOUT,
  output logic            OVF
);

  localparam int N  = SIZE / CHUNK;
  localparam int KW = $clog2(N + 1);
  localparam logic [KW-1:0] LAST = KW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [KW-1:0]   k;
  logic            brw;
  // Operands shift right by CHUNK every CALC cycle, so the chunk
  // being resolved always sits in the low bits.
  logic [SIZE-1:0] a_q;
  logic [SIZE-1:0] b_q;
  logic [SIZE-1:0] res_q;
  // The sign bits are shifted out of a_q and b_q during CALC.
  // The overflow check needs them, so they are kept here.
  logic            a_msb;
  logic            b_msb;

  logic [CHUNK-1:0]      d_chunk;
  logic                  bw_chain;
  logic [SIZE+CHUNK-1:0] res_cat;
  logic [SIZE-1:0]       res_next;

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);

  // Ripple-borrow chain across the current chunk.
  always_comb begin
    bw_chain = brw;
    d_chunk  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      d_chunk[i] = a_q[i] ^ b_q[i] ^ bw_chain;
      bw_chain   = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & bw_chain);
    end
  end

  // New chunk enters at the top of the result register.
  // After N cycles, chunk 0 has reached bit 0.
  assign res_cat  = {d_chunk, res_q};
  assign res_next = res_cat[SIZE+CHUNK-1:CHUNK];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      brw   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      DIFF  <= '0;
      BOUT  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q   <= A;
            b_q   <= B;
            a_msb <= A[SIZE-1];
            b_msb <= B[SIZE-1];
            brw   <= BIN;
            k     <= '0;
            res_q <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          res_q <= res_next;
          brw   <= bw_chain;
          k     <= k + 1'b1;
          if (k == LAST) begin
            DIFF  <= res_next;
            BOUT  <= bw_chain;
            OVF   <= (a_msb != b_msb) && (res_next[SIZE-1] != a_msb);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: self-checking bench for serial_ripple_subtractor at SIZE=10, CHUNK=2.
// Expected results are queued at input accept and compared when the output handshake fires.
// It covers latency, backpressure hold and reset abort.

module tb_serial_ripple_subtractor;

  localparam int SIZE = 10;
  localparam int LAT  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] B;
  logic            BIN;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] DIFF;
  logic            BOUT;
  logic            OVF;

  int tot = 0;
  int bad = 0;

  logic [11:0] exp_q[$];   // {diff, bout, ovf}

  serial_ripple_subtractor #(.SIZE(SIZE), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .BIN(BIN), .out_valid(out_valid), .out_ready(out_ready),
    .DIFF(DIFF), .BOUT(BOUT), .OVF(OVF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int expv);
    tot++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic logic [11:0] model(input logic [9:0] a, input logic [9:0] b, input logic bin);
    logic [10:0] t;
    logic        ovf;
    t   = {1'b0, a} - {1'b0, b} - {10'd0, bin};
    ovf = (a[9] != b[9]) && (t[9] != a[9]);
    return {t[9:0], t[10], ovf};
  endfunction

  // Scoreboard: compare on each output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("diff", int'(DIFF), int'(e[11:2]));
        chk("bout", int'(BOUT), int'(e[1]));
        chk("ovf",  int'(OVF),  int'(e[0]));
      end
    end
  end

  // Offer one operation, check the accept and the latency.
  // If hold is set, backpressure for 3 cycles while poking inputs.
  task automatic run_op(input logic [9:0] a, input logic [9:0] b, input logic bin, input bit hold);
    int lat;
    logic [11:0] e;
    @(posedge clk); #1;
    out_ready = !hold;
    in_valid  = 1'b1; A = a; B = b; BIN = bin;
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    e = model(a, b, bin);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    A = 10'($urandom); B = 10'($urandom); BIN = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    chk("latency", lat, LAT);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        in_valid = ~in_valid;
        A = 10'($urandom);
        @(negedge clk);
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_in_ready", int'(in_ready), 0);
        chk("hold_diff", int'(DIFF), int'(e[11:2]));
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_out", int'(in_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; BIN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_diff", int'(DIFF), 0);
    chk("rst_bout", int'(BOUT), 0);
    chk("rst_ovf", int'(OVF), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    run_op(10'd700, 10'd200, 1'b0, 1'b0);
    run_op(10'd5, 10'd9, 1'b1, 1'b0);
    run_op(10'd0, 10'd0, 1'b1, 1'b0);
    run_op(10'h200, 10'd1, 1'b0, 1'b0);
    run_op(10'd1000, 10'd3, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      run_op(10'($urandom), 10'($urandom), 1'($urandom), 1'b0);

    // Abort an operation with reset during its second CALC cycle.
    @(posedge clk); #1;
    in_valid = 1'b1; A = 10'd100; B = 10'd50; BIN = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", int'(out_valid), 0);
    end
    run_op(10'd3, 10'd1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/serial_ripple_subtractor.md
SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

Interface
REQ-001 Parameter SIZE, default 10, SHALL set the operand and result width in bits.
REQ-002 Parameter CHUNK, default 2, SHALL set the bits resolved per cycle; SIZE SHALL be an integer multiple of CHUNK, and N = SIZE/CHUNK.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the synchronous, active-low reset.
REQ-005 Port in_valid, input, 1, SHALL indicate that the operands on A, B and BIN are valid.
REQ-006 Port in_ready, output, 1, SHALL indicate that the block accepts operands this cycle.
REQ-007 Port A, input, SIZE, SHALL carry the minuend.
REQ-008 Port B, input, SIZE, SHALL carry the subtrahend.
REQ-009 Port BIN, input, 1, SHALL carry the borrow-in.
REQ-010 Port out_valid, output, 1, SHALL indicate that the result is valid.
REQ-011 Port out_ready, input, 1, SHALL indicate that the consumer accepts the result.
REQ-012 Port DIFF, output, SIZE, SHALL carry the difference (A - B - BIN) mod 2^SIZE.
REQ-013 Port BOUT, output, 1, SHALL carry the borrow-out: 1 iff A < B + BIN, unsigned.
REQ-014 Port OVF, output, 1, SHALL carry the two's-complement overflow of the signed subtraction.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, CALC and DONE; there SHALL be no other states.
REQ-016 in_ready SHALL be 1 only in IDLE with rst_n=1; an input transfer SHALL occur when in_valid and in_ready are both 1.
REQ-017 On an input transfer the block SHALL latch A, B and BIN, clear the chunk counter k to 0, load the borrow register with BIN, and enter CALC.
REQ-018 In CALC, each cycle SHALL resolve bits [k*CHUNK +: CHUNK] as a ripple-borrow chain on the latched operands, store the result bits, update the borrow register, and increment k.
REQ-019 When the chunk with k = N-1 has been resolved, the FSM SHALL enter DONE on the same edge, with out_valid=1 and DIFF, BOUT and OVF registered.
REQ-020 Latency SHALL be exactly N clock cycles from the input-transfer edge to the first cycle with out_valid=1 (5 cycles at the defaults).
REQ-021 BOUT SHALL equal the final borrow register value.
REQ-022 OVF SHALL be 1 iff A[MSB] != B[MSB] and DIFF[MSB] != A[MSB].
REQ-023 In DONE, DIFF, BOUT and OVF SHALL hold stable until an output transfer (out_valid and out_ready both 1).
REQ-024 On an output transfer the FSM SHALL return to IDLE, so in_ready=1 on the next cycle; there is no overlap of input and output transfers.
REQ-025 in_valid in CALC or DONE SHALL be ignored, and changes on A, B or BIN after acceptance SHALL NOT affect the result.
REQ-026 Outside DONE, out_valid SHALL be 0; DIFF, BOUT and OVF SHALL keep their last values and are don't-care to the consumer.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 The k counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-029 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE, and k, the borrow register, DIFF, BOUT, OVF and out_valid SHALL all be cleared to 0.
REQ-030 in_ready SHALL be 0 during the reset cycles and SHALL be 1 in the first cycle after rst_n returns to 1.
REQ-031 A reset asserted in CALC or DONE SHALL abort the operation; the aborted result SHALL never produce out_valid=1.

Verification (SIZE=10, CHUNK=2)
REQ-032 A=700, B=200, BIN=0 -> DIFF=500, BOUT=0, OVF=0, with out_valid high exactly 5 cycles after acceptance.
REQ-033 A=5, B=9, BIN=1 -> DIFF=1019, BOUT=1, OVF=0.
REQ-034 A=0, B=0, BIN=1 (borrow ripples through every chunk) -> DIFF=1023, BOUT=1, OVF=0.
REQ-035 A=10'h200, B=1, BIN=0 -> DIFF=10'h1FF, BOUT=0, OVF=1.
REQ-036 Hold out_ready=0 for 3 cycles in DONE while toggling in_valid and A -> DIFF stays stable, in_ready=0 and no new acceptance; then out_ready=1 -> in_ready=1 on the next cycle.
REQ-037 Drive rst_n=0 for 1 cycle at the 2nd CALC cycle -> out_valid never asserts for that operation, and a following A=3, B=1 operation gives DIFF=2, BOUT=0.
